// File: rtl/l2_pkg.sv
// Shared types and constants for the L2 read-port arbiter.
package l2_pkg;

  localparam int L2_BLOCK_W = 256;
  localparam int L2_ADDR_W  = 32;
  localparam int D_BURST_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DRAIN  = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

  // Saturating increment for the consecutive-D-grant counter.
  function automatic logic [D_BURST_W-1:0] burst_inc(input logic [D_BURST_W-1:0] v);
    logic [D_BURST_W-1:0] r;
    if (v == {D_BURST_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(D_BURST_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/l2_arb_pick.sv
// Winner selection between icache and dcache, plus the next value of the
// consecutive-D-grant counter that applies if this pick becomes a grant.
module l2_arb_pick
  import l2_pkg::*;
#(
  parameter int D_PRIORITY  = 1,
  parameter int MAX_D_BURST = 4
) (
  input  logic                 i_req,
  input  logic                 d_req,
  input  req_id_t              last_grant,
  input  logic [D_BURST_W-1:0] d_burst,
  output req_id_t              winner,
  output logic [D_BURST_W-1:0] d_burst_nxt
);

  localparam logic [D_BURST_W-1:0] BURST_LIM = D_BURST_W'(MAX_D_BURST);

  // Choose the requester to grant; ties resolved by priority+burst cap or round-robin.
  always_comb begin
    winner = REQ_I;
    if (i_req && d_req) begin
      if (D_PRIORITY != 0) begin
        if (d_burst >= BURST_LIM) begin
          winner = REQ_I;
        end else begin
          winner = REQ_D;
        end
      end else begin
        if (last_grant == REQ_I) begin
          winner = REQ_D;
        end else begin
          winner = REQ_I;
        end
      end
    end else if (d_req) begin
      winner = REQ_D;
    end else begin
      winner = REQ_I;
    end
  end

  // Count D grants only while I is being held off; any other grant resets the run.
  always_comb begin
    d_burst_nxt = {D_BURST_W{1'b0}};
    if (winner == REQ_D) begin
      if (i_req) begin
        d_burst_nxt = burst_inc(d_burst);
      end else begin
        d_burst_nxt = {D_BURST_W{1'b0}};
      end
    end else begin
      d_burst_nxt = {D_BURST_W{1'b0}};
    end
  end

endmodule

// File: rtl/l2_read_arbiter.sv
// Arbitrates the single L2 read port between the L1 icache and dcache.
// Holds the granted address for the whole transaction and drains aborted
// requests so the L2 never sees a dangling read.
module l2_read_arbiter
  import l2_pkg::*;
#(
  parameter int D_PRIORITY  = 1,
  parameter int MAX_D_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read_en,
  input  logic [L2_ADDR_W-1:0]  i_addr,
  output logic [L2_BLOCK_W-1:0] i_block,
  output logic                  i_stall,
  input  logic                  d_read_en,
  input  logic [L2_ADDR_W-1:0]  d_addr,
  output logic [L2_BLOCK_W-1:0] d_block,
  output logic                  d_stall,
  output logic                  L2_read_en,
  output logic [L2_ADDR_W-1:0]  L2_addr_read,
  input  logic [L2_BLOCK_W-1:0] L2_block_read,
  input  logic                  L2_stall
);

  arb_state_t           state_r, state_nxt_s;
  logic [L2_ADDR_W-1:0] addr_r, addr_nxt_s;
  req_id_t              last_grant_r, last_grant_nxt_s;
  logic [D_BURST_W-1:0] d_burst_r, d_burst_nxt_s;
  req_id_t              pick_winner_s;
  logic [D_BURST_W-1:0] pick_burst_s;
  logic                 i_abort_s, d_abort_s;

  l2_arb_pick #(
    .D_PRIORITY (D_PRIORITY),
    .MAX_D_BURST(MAX_D_BURST)
  ) u_pick (
    .i_req      (i_read_en),
    .d_req      (d_read_en),
    .last_grant (last_grant_r),
    .d_burst    (d_burst_r),
    .winner     (pick_winner_s),
    .d_burst_nxt(pick_burst_s)
  );

  // A requester abandons its transaction by dropping read_en or moving its address.
  assign i_abort_s = !i_read_en || (i_addr != addr_r);
  assign d_abort_s = !d_read_en || (d_addr != addr_r);

  // State, latched address and fairness bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      addr_r       <= {L2_ADDR_W{1'b0}};
      last_grant_r <= REQ_I;
      d_burst_r    <= {D_BURST_W{1'b0}};
    end else begin
      state_r      <= state_nxt_s;
      addr_r       <= addr_nxt_s;
      last_grant_r <= last_grant_nxt_s;
      d_burst_r    <= d_burst_nxt_s;
    end
  end

  // Next-state logic: grant only from IDLE, completion beats abort.
  always_comb begin
    state_nxt_s      = state_r;
    addr_nxt_s       = addr_r;
    last_grant_nxt_s = last_grant_r;
    d_burst_nxt_s    = d_burst_r;
    case (state_r)
      IDLE: begin
        if (i_read_en || d_read_en) begin
          last_grant_nxt_s = pick_winner_s;
          d_burst_nxt_s    = pick_burst_s;
          if (pick_winner_s == REQ_D) begin
            state_nxt_s = BUSY_D;
            addr_nxt_s  = d_addr;
          end else begin
            state_nxt_s = BUSY_I;
            addr_nxt_s  = i_addr;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY_I: begin
        if (!L2_stall) begin
          state_nxt_s = IDLE;
        end else if (i_abort_s) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = BUSY_I;
        end
      end
      BUSY_D: begin
        if (!L2_stall) begin
          state_nxt_s = IDLE;
        end else if (d_abort_s) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = BUSY_D;
        end
      end
      DRAIN: begin
        if (!L2_stall) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // L2 side: request is a pure state decode, address comes straight from the latch.
  assign L2_read_en   = (state_r != IDLE);
  assign L2_addr_read = addr_r;

  // L1 side: data is broadcast; the stall tells each cache when it is valid for it.
  assign i_block = L2_block_read;
  assign d_block = L2_block_read;
  assign i_stall = i_read_en & ~((state_r == BUSY_I) & ~L2_stall & (i_addr == addr_r));
  assign d_stall = d_read_en & ~((state_r == BUSY_D) & ~L2_stall & (d_addr == addr_r));

endmodule

// File: tb/tb_l2_read_arbiter.sv
// Directed self-checking bench for l2_read_arbiter. Three instances share
// the same stimulus: defaults, MAX_D_BURST=2, and pure round-robin.
module tb_l2_read_arbiter;

  localparam logic [1:0] G_NONE = 2'd0;
  localparam logic [1:0] G_I    = 2'd1;
  localparam logic [1:0] G_D    = 2'd2;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_read_en, d_read_en, L2_stall;
  logic [31:0]  i_addr, d_addr;
  logic [255:0] L2_block_read;

  logic [255:0] a_i_block, a_d_block, b_i_block, b_d_block, c_i_block, c_d_block;
  logic         a_i_stall, a_d_stall, a_rd, b_i_stall, b_d_stall, b_rd;
  logic         c_i_stall, c_d_stall, c_rd;
  logic [31:0]  a_addr, b_addr, c_addr;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  l2_read_arbiter #(.D_PRIORITY(1), .MAX_D_BURST(4)) dut_a (
    .clk(clk), .rst(rst),
    .i_read_en(i_read_en), .i_addr(i_addr), .i_block(a_i_block), .i_stall(a_i_stall),
    .d_read_en(d_read_en), .d_addr(d_addr), .d_block(a_d_block), .d_stall(a_d_stall),
    .L2_read_en(a_rd), .L2_addr_read(a_addr), .L2_block_read(L2_block_read), .L2_stall(L2_stall)
  );

  l2_read_arbiter #(.D_PRIORITY(1), .MAX_D_BURST(2)) dut_b (
    .clk(clk), .rst(rst),
    .i_read_en(i_read_en), .i_addr(i_addr), .i_block(b_i_block), .i_stall(b_i_stall),
    .d_read_en(d_read_en), .d_addr(d_addr), .d_block(b_d_block), .d_stall(b_d_stall),
    .L2_read_en(b_rd), .L2_addr_read(b_addr), .L2_block_read(L2_block_read), .L2_stall(L2_stall)
  );

  l2_read_arbiter #(.D_PRIORITY(0), .MAX_D_BURST(4)) dut_c (
    .clk(clk), .rst(rst),
    .i_read_en(i_read_en), .i_addr(i_addr), .i_block(c_i_block), .i_stall(c_i_stall),
    .d_read_en(d_read_en), .d_addr(d_addr), .d_block(c_d_block), .d_stall(c_d_stall),
    .L2_read_en(c_rd), .L2_addr_read(c_addr), .L2_block_read(L2_block_read), .L2_stall(L2_stall)
  );

  // Which requester is being served in a BUSY cycle with a zero-wait L2.
  function automatic logic [1:0] grant_of(input logic rd, input logic is, input logic ds);
    if (rd && !is && ds) return G_I;
    else if (rd && is && !ds) return G_D;
    else return G_NONE;
  endfunction

  task automatic do_reset;
    rst = 1'b1; i_read_en = 1'b0; d_read_en = 1'b0;
    i_addr = 32'h0; d_addr = 32'h0; L2_stall = 1'b0; L2_block_read = 256'h0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    i_read_en = 1'b1; i_addr = 32'h0000_1234;
    #1;
    total_cnt++; if (a_rd !== 1'b0) $display("FAIL rst_rd: got %b want 0", a_rd); else pass_cnt++;
    total_cnt++; if (a_addr !== 32'h0) $display("FAIL rst_addr: got %h want 0", a_addr); else pass_cnt++;
    total_cnt++; if (a_i_stall !== 1'b1) $display("FAIL rst_i_stall: got %b want 1", a_i_stall); else pass_cnt++;
    total_cnt++; if (a_d_stall !== 1'b0) $display("FAIL rst_d_stall: got %b want 0", a_d_stall); else pass_cnt++;
    i_read_en = 1'b0; d_read_en = 1'b1;
    #1;
    total_cnt++; if (a_d_stall !== 1'b1) $display("FAIL rst_d_stall_req: got %b want 1", a_d_stall); else pass_cnt++;
    total_cnt++; if (a_i_stall !== 1'b0) $display("FAIL rst_i_stall_idle: got %b want 0", a_i_stall); else pass_cnt++;
    d_read_en = 1'b0;
  endtask

  task automatic test_single_i;
    logic [255:0] blk;
    blk = {8{32'hDEAD_BEEF}};
    do_reset();
    i_read_en = 1'b1; i_addr = 32'h0000_1000; L2_stall = 1'b1;
    #1;
    total_cnt++; if (a_rd !== 1'b0) $display("FAIL single_c0_rd: got %b want 0", a_rd); else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++; if (a_rd !== 1'b1) $display("FAIL single_c1_rd: got %b want 1", a_rd); else pass_cnt++;
    total_cnt++; if (a_addr !== 32'h0000_1000) $display("FAIL single_c1_addr: got %h want 1000", a_addr); else pass_cnt++;
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) begin
        @(negedge clk); #1;
      end
      total_cnt++; if (a_i_stall !== 1'b1) $display("FAIL single_stall_c%0d: got %b want 1", c, a_i_stall); else pass_cnt++;
      total_cnt++; if (a_d_stall !== 1'b0) $display("FAIL single_dstall_c%0d: got %b want 0", c, a_d_stall); else pass_cnt++;
    end
    @(negedge clk);
    L2_stall = 1'b0; L2_block_read = blk;
    #1;
    total_cnt++; if (a_i_stall !== 1'b0) $display("FAIL single_c4_stall: got %b want 0", a_i_stall); else pass_cnt++;
    total_cnt++; if (a_i_block !== blk) $display("FAIL single_c4_block: got %h want %h", a_i_block[31:0], blk[31:0]); else pass_cnt++;
    @(negedge clk);
    i_read_en = 1'b0; L2_stall = 1'b1;
    #1;
    total_cnt++; if (a_rd !== 1'b0) $display("FAIL single_c5_idle: got %b want 0", a_rd); else pass_cnt++;
    total_cnt++; if (a_addr !== 32'h0000_1000) $display("FAIL single_c5_addr: got %h want 1000", a_addr); else pass_cnt++;
  endtask

  task automatic test_tie_priority;
    do_reset();
    i_read_en = 1'b1; i_addr = 32'h100; d_read_en = 1'b1; d_addr = 32'h200; L2_stall = 1'b0;
    @(negedge clk); #1;
    total_cnt++; if (a_addr !== 32'h200) $display("FAIL tie_first_addr: got %h want 200", a_addr); else pass_cnt++;
    total_cnt++; if (a_d_stall !== 1'b0) $display("FAIL tie_d_done: got %b want 0", a_d_stall); else pass_cnt++;
    total_cnt++; if (a_i_stall !== 1'b1) $display("FAIL tie_i_wait: got %b want 1", a_i_stall); else pass_cnt++;
    @(negedge clk);
    d_read_en = 1'b0;
    #1;
    total_cnt++; if (a_rd !== 1'b0) $display("FAIL tie_turnaround: got %b want 0", a_rd); else pass_cnt++;
    total_cnt++; if (a_i_stall !== 1'b1) $display("FAIL tie_i_turn: got %b want 1", a_i_stall); else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++; if (a_addr !== 32'h100) $display("FAIL tie_second_addr: got %h want 100", a_addr); else pass_cnt++;
    total_cnt++; if (a_i_stall !== 1'b0) $display("FAIL tie_i_done: got %b want 0", a_i_stall); else pass_cnt++;
    @(negedge clk);
    i_read_en = 1'b0;
  endtask

  task automatic test_burst;
    logic [1:0] exp_a [6];
    logic [1:0] exp_b [6];
    logic [1:0] exp_c [6];
    logic [1:0] g;
    exp_a = '{G_D, G_D, G_D, G_D, G_I, G_D};
    exp_b = '{G_D, G_D, G_I, G_D, G_D, G_I};
    exp_c = '{G_D, G_I, G_D, G_I, G_D, G_I};
    do_reset();
    i_read_en = 1'b1; i_addr = 32'h100; d_read_en = 1'b1; d_addr = 32'h200; L2_stall = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1;
      g = grant_of(a_rd, a_i_stall, a_d_stall);
      total_cnt++; if (g !== exp_a[k]) $display("FAIL burst4_grant%0d: got %0d want %0d", k, g, exp_a[k]); else pass_cnt++;
      g = grant_of(b_rd, b_i_stall, b_d_stall);
      total_cnt++; if (g !== exp_b[k]) $display("FAIL burst2_grant%0d: got %0d want %0d", k, g, exp_b[k]); else pass_cnt++;
      g = grant_of(c_rd, c_i_stall, c_d_stall);
      total_cnt++; if (g !== exp_c[k]) $display("FAIL rr_grant%0d: got %0d want %0d", k, g, exp_c[k]); else pass_cnt++;
      @(negedge clk);
    end
    i_read_en = 1'b0; d_read_en = 1'b0;
  endtask

  task automatic test_abort;
    do_reset();
    i_read_en = 1'b1; i_addr = 32'h40; L2_stall = 1'b1;
    @(negedge clk);
    i_addr = 32'h80;
    #1;
    total_cnt++; if (a_addr !== 32'h40) $display("FAIL abort_busy_addr: got %h want 40", a_addr); else pass_cnt++;
    total_cnt++; if (a_i_stall !== 1'b1) $display("FAIL abort_busy_stall: got %b want 1", a_i_stall); else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++; if (a_rd !== 1'b1) $display("FAIL abort_drain_rd: got %b want 1", a_rd); else pass_cnt++;
    total_cnt++; if (a_addr !== 32'h40) $display("FAIL abort_drain_addr: got %h want 40", a_addr); else pass_cnt++;
    total_cnt++; if (a_i_stall !== 1'b1) $display("FAIL abort_drain_stall: got %b want 1", a_i_stall); else pass_cnt++;
    @(negedge clk);
    L2_stall = 1'b0;
    #1;
    total_cnt++; if (a_i_stall !== 1'b1) $display("FAIL abort_drain_done_stall: got %b want 1", a_i_stall); else pass_cnt++;
    total_cnt++; if (a_addr !== 32'h40) $display("FAIL abort_drain_done_addr: got %h want 40", a_addr); else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++; if (a_rd !== 1'b0) $display("FAIL abort_idle_rd: got %b want 0", a_rd); else pass_cnt++;
    total_cnt++; if (a_i_stall !== 1'b1) $display("FAIL abort_idle_stall: got %b want 1", a_i_stall); else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++; if (a_addr !== 32'h80) $display("FAIL abort_regrant_addr: got %h want 80", a_addr); else pass_cnt++;
    total_cnt++; if (a_i_stall !== 1'b0) $display("FAIL abort_regrant_stall: got %b want 0", a_i_stall); else pass_cnt++;
    // read_en drop variant
    do_reset();
    i_read_en = 1'b1; i_addr = 32'h40; L2_stall = 1'b1;
    @(negedge clk);
    i_read_en = 1'b0;
    #1;
    total_cnt++; if (a_i_stall !== 1'b0) $display("FAIL drop_stall: got %b want 0", a_i_stall); else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++; if (a_rd !== 1'b1) $display("FAIL drop_drain_rd: got %b want 1", a_rd); else pass_cnt++;
    @(negedge clk);
    L2_stall = 1'b0;
    @(negedge clk); #1;
    total_cnt++; if (a_rd !== 1'b0) $display("FAIL drop_idle_rd: got %b want 0", a_rd); else pass_cnt++;
  endtask

  task automatic test_reset_busy_d;
    do_reset();
    d_read_en = 1'b1; d_addr = 32'h300; L2_stall = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    total_cnt++; if (a_rd !== 1'b1) $display("FAIL rstd_busy_rd: got %b want 1", a_rd); else pass_cnt++;
    total_cnt++; if (a_addr !== 32'h300) $display("FAIL rstd_busy_addr: got %h want 300", a_addr); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total_cnt++; if (a_rd !== 1'b0) $display("FAIL rstd_rd: got %b want 0", a_rd); else pass_cnt++;
    total_cnt++; if (a_d_stall !== 1'b1) $display("FAIL rstd_d_stall: got %b want 1", a_d_stall); else pass_cnt++;
    total_cnt++; if (a_addr !== 32'h0) $display("FAIL rstd_addr: got %h want 0", a_addr); else pass_cnt++;
    d_read_en = 1'b0;
  endtask

  task automatic test_complete_abort;
    do_reset();
    i_read_en = 1'b1; i_addr = 32'h500; L2_stall = 1'b1;
    @(negedge clk);
    L2_stall = 1'b0; i_addr = 32'h600;
    #1;
    total_cnt++; if (a_i_stall !== 1'b1) $display("FAIL cmpab_stall: got %b want 1", a_i_stall); else pass_cnt++;
    @(negedge clk);
    i_read_en = 1'b0; L2_stall = 1'b1;
    #1;
    total_cnt++; if (a_rd !== 1'b0) $display("FAIL cmpab_idle_rd: got %b want 0", a_rd); else pass_cnt++;
    do_reset();
    d_read_en = 1'b1; d_addr = 32'h700; L2_stall = 1'b1;
    @(negedge clk);
    L2_stall = 1'b0; d_read_en = 1'b0;
    #1;
    total_cnt++; if (a_d_stall !== 1'b0) $display("FAIL cmpab_d_stall: got %b want 0", a_d_stall); else pass_cnt++;
    @(negedge clk);
    L2_stall = 1'b1;
    #1;
    total_cnt++; if (a_rd !== 1'b0) $display("FAIL cmpab_d_idle_rd: got %b want 0", a_rd); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_i();
    test_tie_priority();
    test_burst();
    test_abort();
    test_reset_busy_d();
    test_complete_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
